lenet_image_loader: RTL and testbench

// - Write-side front end for Lenet_accelerator: turns a serial pixel stream into the parallel 28x28 image it reads.
// - Ping-pong buffered: one bank fills from the stream while the other is held stable on image_out for the accelerator.
// - Hands each complete frame over with a valid/ack handshake and flags framing errors on s_last.

---
 rtl/lenet_image_loader_pkg.sv | 27 ++
 rtl/lenet_image_loader_if.sv | 37 +++
 rtl/lenet_image_loader_frame_bank.sv | 27 ++
 rtl/lenet_image_loader.sv | 135 +++++++++++++
 tb/tb_lenet_image_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/lenet_image_loader_pkg.sv
// Shared sizes, pixel type and FSM encodings for the LeNet image loader.
// Pixels are signed fixed-point and are stored exactly as received.
package lenet_image_loader_pkg;

    localparam int BITWIDTH   = 16;
    localparam int IMG_DIM    = 28;
    localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
    localparam int ADDR_W     = 10;
    localparam int IMG_W      = IMG_PIXELS * BITWIDTH;

    typedef logic signed [BITWIDTH-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]          addr_t;

    localparam addr_t LAST_ADDR = addr_t'(IMG_PIXELS - 1);

    localparam logic [0:0] FILL_FILLING = 1'b0;
    localparam logic [0:0] FILL_FULL    = 1'b1;

    localparam logic [0:0] OUT_EMPTY = 1'b0;
    localparam logic [0:0] OUT_HOLD  = 1'b1;

    // Bit offset of pixel (r,c) inside the flattened image vector.
    function automatic int unsigned pix_offset(input int unsigned r, input int unsigned c);
        return (r * IMG_DIM + c) * BITWIDTH;
    endfunction

endpackage

// File: rtl/lenet_image_loader_if.sv
// Pixel stream in, parallel frame out, plus the frame handshake and error flag.
// The loader takes the slave view; the stream source / accelerator side takes master.
interface lenet_image_loader_if;
    import lenet_image_loader_pkg::*;

    logic             s_valid;
    logic             s_ready;
    pixel_t           s_data;
    logic             s_last;
    logic [IMG_W-1:0] image_out;
    logic             image_valid;
    logic             image_ack;
    logic             frame_err;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output image_ack,
        input  s_ready,
        input  image_out,
        input  image_valid,
        input  frame_err
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  image_ack,
        output s_ready,
        output image_out,
        output image_valid,
        output frame_err
    );

endinterface

// File: rtl/lenet_image_loader_frame_bank.sv
// One full-frame pixel register bank: single write port, whole frame visible
// on a flattened read port so the accelerator can consume it in parallel.
module lenet_image_loader_frame_bank
    import lenet_image_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  addr_t            addr_i,
    input  pixel_t           data_i,
    output logic [IMG_W-1:0] rd_o
);

    logic [IMG_W-1:0] mem_q;

    // Pixel storage; writes outside the frame are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (we_i && (addr_i <= LAST_ADDR)) begin
            mem_q[int'(addr_i) * BITWIDTH +: BITWIDTH] <= data_i;
        end
    end

    assign rd_o = mem_q;

endmodule

// File: rtl/lenet_image_loader.sv
// Ping-pong loader: one bank fills from the pixel stream while the other is
// held on image_out; completed frames are handed over with valid/ack.
module lenet_image_loader
    import lenet_image_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    lenet_image_loader_if.slave  bus
);

    addr_t      cnt_q, cnt_d;
    logic [0:0] fill_q, fill_d;
    logic [0:0] out_q, out_d;
    logic       sel_q, sel_d;
    logic       err_q, err_d;

    logic             accept_s;
    logic             last_beat_s;
    logic             fill_done_s;
    logic             swap_s;
    logic [IMG_W-1:0] bank0_rd_s;
    logic [IMG_W-1:0] bank1_rd_s;

    assign accept_s    = bus.s_valid && (fill_q == FILL_FILLING);
    assign last_beat_s = accept_s && (cnt_q == LAST_ADDR);
    assign fill_done_s = (fill_q == FILL_FULL) || last_beat_s;
    // A finished frame moves to the output side as soon as nothing is held or the held one is acked.
    assign swap_s      = fill_done_s && ((out_q == OUT_EMPTY) || bus.image_ack);

    // Next-state logic for the counter, both FSMs, bank select and error pulse.
    always_comb begin
        cnt_d  = cnt_q;
        fill_d = fill_q;
        out_d  = out_q;
        sel_d  = sel_q;
        err_d  = 1'b0;

        if (accept_s) begin
            if (last_beat_s || bus.s_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + addr_t'(1'b1);
            end
            err_d = bus.s_last ^ last_beat_s;
        end else begin
            cnt_d = cnt_q;
        end

        case (fill_q)
            FILL_FILLING: begin
                if (last_beat_s && !swap_s) begin
                    fill_d = FILL_FULL;
                end else begin
                    fill_d = FILL_FILLING;
                end
            end
            FILL_FULL: begin
                if (swap_s) begin
                    fill_d = FILL_FILLING;
                end else begin
                    fill_d = FILL_FULL;
                end
            end
            default: fill_d = FILL_FILLING;
        endcase

        case (out_q)
            OUT_EMPTY: begin
                if (swap_s) begin
                    out_d = OUT_HOLD;
                end else begin
                    out_d = OUT_EMPTY;
                end
            end
            OUT_HOLD: begin
                if (swap_s) begin
                    out_d = OUT_HOLD;
                end else if (bus.image_ack) begin
                    out_d = OUT_EMPTY;
                end else begin
                    out_d = OUT_HOLD;
                end
            end
            default: out_d = OUT_EMPTY;
        endcase

        if (swap_s) begin
            sel_d = ~sel_q;
        end else begin
            sel_d = sel_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            fill_q <= FILL_FILLING;
            out_q  <= OUT_EMPTY;
            sel_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            sel_q  <= sel_d;
            err_q  <= err_d;
        end
    end

    // sel_q names the bank being filled; the other one drives image_out.
    lenet_image_loader_frame_bank u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .we_i   (accept_s && !sel_q),
        .addr_i (cnt_q),
        .data_i (bus.s_data),
        .rd_o   (bank0_rd_s)
    );

    lenet_image_loader_frame_bank u_bank1 (
        .clk    (clk),
        .rst    (rst),
        .we_i   (accept_s && sel_q),
        .addr_i (cnt_q),
        .data_i (bus.s_data),
        .rd_o   (bank1_rd_s)
    );

    assign bus.image_out   = sel_q ? bank0_rd_s : bank1_rd_s;
    assign bus.s_ready     = (fill_q == FILL_FILLING);
    assign bus.image_valid = (out_q == OUT_HOLD);
    assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_lenet_image_loader.sv
// Directed bench for lenet_image_loader: stimulus pushes expected frames and
// error pulses into queues, a negedge monitor pops and compares them.
module tb_lenet_image_loader;
    import lenet_image_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;

    lenet_image_loader_if bus();

    lenet_image_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int exp_frames[$];
    int exp_errs[$];

    logic             prev_valid = 1'b0;
    logic [IMG_W-1:0] prev_out   = '0;
    logic             watch_valid = 1'b0;
    int               valid_drops = 0;
    int               mon_base;
    int               mon_bad;
    int               mon_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pix(input int unsigned r, input int unsigned c);
        return 32'(bus.image_out[pix_offset(r, c) +: BITWIDTH]);
    endfunction

    // Scoreboard monitor: frame presentations and frame_err pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_out   = '0;
        end else begin
            if (watch_valid && !bus.image_valid) valid_drops++;
            if (bus.frame_err) begin
                check("frame_err_expected", 32'(exp_errs.size() > 0), 32'd1);
                if (exp_errs.size() > 0) begin
                    mon_err = exp_errs.pop_front();
                    check("frame_err_cycle", cyc, mon_err);
                end
            end
            if (bus.image_valid && (!prev_valid || (bus.image_out !== prev_out))) begin
                check("frame_expected", 32'(exp_frames.size() > 0), 32'd1);
                if (exp_frames.size() > 0) begin
                    mon_base = exp_frames.pop_front();
                    mon_bad  = 0;
                    for (int i = 0; i < IMG_PIXELS; i++) begin
                        if (bus.image_out[i*BITWIDTH +: BITWIDTH] !== 16'(mon_base + i)) mon_bad++;
                    end
                    check($sformatf("frame_pixels_base%0d", mon_base), mon_bad, 0);
                end
            end
            prev_valid = bus.image_valid;
            prev_out   = bus.image_out;
        end
    end

    task automatic send_beat(input int d, input logic l, input logic ack);
        int n;
        n = 0;
        bus.s_valid   = 1'b1;
        bus.s_data    = 16'(d);
        bus.s_last    = l;
        bus.image_ack = ack;
        while (n < 200) begin
            @(negedge clk);
            if (bus.s_ready) break;
            n++;
        end
        if (n >= 200) check("s_ready_timeout", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.image_ack = 1'b0;
    endtask

    task automatic send_frame(input int base, input int nbeats, input int last_at, input logic ack_last);
        for (int i = 0; i < nbeats; i++) begin
            send_beat(base + i, (i == last_at), ack_last && (i == nbeats - 1));
        end
    endtask

    task automatic pulse_ack();
        bus.image_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.image_ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.image_ack = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_image_valid", 32'(bus.image_valid), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_image_out_zero", 32'(bus.image_out == '0), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Frame A: values = index, valid the cycle after the last beat
        exp_frames.push_back(0);
        send_frame(0, 784, 783, 1'b0);
        check("A_valid_latency", 32'(bus.image_valid), 32'd1);
        check("A_s_ready_no_bubble", 32'(bus.s_ready), 32'd1);
        check("A_pix_27_27", pix(27, 27), 32'd783);
        check("A_pix_1_0", pix(1, 0), 32'd28);

        // Frame B buffered behind A, stream backpressured until ack
        exp_frames.push_back(1000);
        send_frame(1000, 784, 783, 1'b0);
        check("B_s_ready_drop", 32'(bus.s_ready), 32'd0);
        check("B_holds_A", pix(0, 0), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("B_backpressure", 32'(bus.s_ready), 32'd0);
        check("B_still_A", pix(27, 27), 32'd783);
        pulse_ack();
        check("B_swap_on_ack", pix(0, 0), 32'd1000);
        check("B_valid_kept", 32'(bus.image_valid), 32'd1);
        check("B_pix_27_27", pix(27, 27), 32'd1783);
        check("B_s_ready_resume", 32'(bus.s_ready), 32'd1);

        // Frame C: ack coincides with its last beat, no valid gap
        exp_frames.push_back(2000);
        watch_valid = 1'b1;
        send_frame(2000, 784, 783, 1'b1);
        check("C_swap_same_cycle", pix(0, 0), 32'd2000);
        check("C_valid", 32'(bus.image_valid), 32'd1);
        check("C_s_ready", 32'(bus.s_ready), 32'd1);
        @(negedge clk);
        #1;
        watch_valid = 1'b0;
        check("C_valid_no_gap", valid_drops, 0);

        // Ack with nothing pending empties; ack while empty is ignored
        pulse_ack();
        check("D_ack_empties", 32'(bus.image_valid), 32'd0);
        pulse_ack();
        check("D_ack_empty_ignored", 32'(bus.image_valid), 32'd0);
        check("D_image_out_stable", pix(0, 0), 32'd2000);

        // Early s_last on beat 99 discards the partial frame
        send_frame(3000, 100, 99, 1'b0);
        exp_errs.push_back(cyc);
        check("E_no_valid", 32'(bus.image_valid), 32'd0);
        exp_frames.push_back(5000);
        send_frame(5000, 784, 783, 1'b0);
        check("E_clean_pix_0_0", pix(0, 0), 32'd5000);
        check("E_clean_pix_27_27", pix(27, 27), 32'd5783);
        pulse_ack();
        check("E_acked", 32'(bus.image_valid), 32'd0);

        // Missing s_last on beat 783: error flagged, frame still committed
        exp_frames.push_back(7000);
        send_frame(7000, 784, -1, 1'b0);
        exp_errs.push_back(cyc);
        check("F_valid", 32'(bus.image_valid), 32'd1);
        check("F_pix_27_27", pix(27, 27), 32'd7783);

        // Reset mid-frame while holding F
        send_frame(9000, 400, -1, 1'b0);
        rst = 1'b1;
        #1;
        check("G_rst_valid", 32'(bus.image_valid), 32'd0);
        check("G_rst_image_out", 32'(bus.image_out == '0), 32'd1);
        check("G_rst_frame_err", 32'(bus.frame_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_frames.push_back(11000);
        send_frame(11000, 784, 783, 1'b0);
        check("G_valid", 32'(bus.image_valid), 32'd1);
        check("G_pix_0_0", pix(0, 0), 32'd11000);
        check("G_pix_27_27", pix(27, 27), 32'd11783);

        repeat (3) @(negedge clk);
        #1;
        check("frames_all_seen", exp_frames.size(), 0);
        check("errs_all_seen", exp_errs.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
